tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-channel time-division demultiplexer: the receiving end of a stream built by the 4:1 mux.
- Accepts one slot per valid cycle, aligns to a slot-0 sync marker, and tracks the current slot.
- Rebuilds the four channel values and presents them as one registered frame.
- Sits between the serial/shared link and per-channel consumers.

## Interface
Parameters:
- DW, 1, data width of one slot / one channel

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous to clk, active-high
- din  input  DW  slot data
- din_valid  input  1  din carries a slot this cycle; low = stall, nothing consumed
- sync  input  1  qualifies din as channel 0; only sampled when din_valid=1
- y  output  4*DW  last complete frame; y[k*DW +: DW] = channel k
- frame_valid  output  1  one-cycle pulse: y updated this cycle
- slot  output  2  slot index expected for the next accepted din (the mux's s)
- locked  output  1  state is LOCKED
- sync_err  output  1  one-cycle pulse: unexpected sync realigned the frame

## Operation
States:
- HUNT (reset state): discard data until din_valid & sync.
  - On that cycle, capture din as ch0, set slot=1, go to LOCKED.
- LOCKED: each din_valid cycle captures din into holding register hold[slot].
  - slot increments mod 4.
  - When slot 3 is captured, copy hold (with ch3 = din) into y and pulse frame_valid.
  - slot wraps 3 -> 0.
- Sync handling in LOCKED:
  - din_valid & sync with slot==0: normal, no error.
  - din_valid & sync with slot!=0: pulse sync_err, discard partial frame (no frame_valid), capture din as ch0, set slot=1. State stays LOCKED.
- din_valid=0: no state, slot, or hold change; frame_valid=0.
- Holding register is not cleared between frames. Every slot is rewritten before use.
- Reset, including mid-frame, has priority over all inputs:
  - y=0, frame_valid=0, sync_err=0, slot=0, locked=0, state=HUNT, hold=0.
  - A sync in the reset cycle is ignored.

## Timing
- All outputs registered. No combinational path from inputs to outputs.
- Latency: slot-3 din accepted on edge N -> y and frame_valid visible after edge N. Frame pulses occur at most once every 4 valid cycles.
- Continuous valid data with sync every 4th slot: frame_valid once per 4 cycles, no stalls required.
- slot output reflects the post-edge value; in HUNT it reads 0.
- sync_err and frame_valid are never both high in the same cycle.

## Configuration
- TDM_DEMUX_PARITY_EN defined:
  - Frame is 5 slots: ch0..ch3, then a parity slot.
  - Slot counter runs 0..4 internally; the slot port shows the low 2 bits and reads 0 during the parity slot.
  - Added output parity_err (1 bit, reset 0). On the parity slot, even parity over the 4*DW+DW bits is checked.
  - Parity OK: y updates and frame_valid pulses on the parity-slot edge.
  - Parity mismatch: y holds, frame_valid stays 0, parity_err pulses for one cycle.
  - Unexpected sync on the parity slot counts as a sync error.
- Not defined: 4-slot frame as above; no parity_err port.

## Structure
- Package tdm_demux_pkg holds:
  - NCH=4
  - slot counter width (2, or 3 with parity)
  - state enum {HUNT, LOCKED}
- One natural sub-module, tdm_slot_ctr: the wrapping slot counter with enable (din_valid), load-to-1 (sync), and clear (rst). It provides the wrap flag used to fire the frame update.
- Capture, y register, and FSM live in the top.

## Test plan
- Reset then idle: rst high 2 cycles -> y=0, frame_valid=0, locked=0, slot=0. Data with sync=0 in HUNT -> locked stays 0, no frame.
- Aligned frame, DW=1: din 1,0,0,0 with sync on the first -> after the 4th edge y=4'b0001, one frame_valid pulse. Then 0,1,0,0 -> y=4'b0010 four cycles later.
- Stalls: same frame as 1,0,1,1 with din_valid low for 3 cycles between slots 1 and 2 -> y=4'b1101; slot holds at 2 during the stall; single pulse.
- Misaligned sync: after 2 slots of a frame, sync arrives -> sync_err pulse, slot=1, no frame_valid. Next 3 slots complete y from the new ch0.
- Reset mid-frame: rst at slot 2 -> next cycle slot=0, locked=0, y=0. Prior partial data never appears in y.
- Parity (TDM_DEMUX_PARITY_EN, DW=1): frame 1,1,0,0 with parity 0 -> y=4'b0011 and frame_valid. Same frame with parity 1 -> parity_err pulse, y unchanged.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the 4-channel TDM demultiplexer.
// Define TDM_DEMUX_PARITY_EN to add a fifth, even-parity slot to every frame.
package tdm_demux_pkg;

  localparam int NCH   = 4;
  localparam int NCH_W = 2;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int NSLOT  = NCH + 1;
  localparam int SLOT_W = 3;
`else
  localparam int NSLOT  = NCH;
  localparam int SLOT_W = 2;
`endif

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] cur);
    return (cur == LAST_SLOT) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter: clear beats load-to-1, which beats increment.
// wrap flags that the last slot of the frame is being accepted this cycle.
module tdm_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  output logic [SLOT_W-1:0] cnt,
  output logic              wrap
);

  assign wrap = en && !load && (cnt == LAST_SLOT);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= SLOT_W'(1);
    end else if (en) begin
      cnt <= next_slot(cnt);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: aligns on the slot-0 sync marker and emits registered frames.
// Optional feature macro: TDM_DEMUX_PARITY_EN (5-slot frame with trailing even-parity slot).
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     din,
  input  logic              din_valid,
  input  logic              sync,
  output logic [NCH*DW-1:0] y,
  output logic              frame_valid,
  output logic [1:0]        slot,
  output logic              locked,
`ifdef TDM_DEMUX_PARITY_EN
  output logic              parity_err,
`endif
  output logic              sync_err
);

  state_e              state;
  state_e              state_nxt;
  logic [SLOT_W-1:0]   cnt;
  logic                wrap;
  logic                accept;
  logic                load_ch0;
  logic                sync_bad;
  logic                hold_we;
  logic                frame_fire;
  logic [NCH*DW-1:0]   frame_nxt;
  logic [DW-1:0]       hold [NCH];

  tdm_slot_ctr u_slot_ctr (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .load (load_ch0),
    .cnt  (cnt),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_ch0  = 1'b0;
    sync_bad  = 1'b0;
    unique case (state)
      HUNT: begin
        if (din_valid && sync) begin
          state_nxt = LOCKED;
          load_ch0  = 1'b1;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          accept   = !sync;
          load_ch0 = sync;
          sync_bad = sync && (cnt != '0);
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Assemble the outgoing frame; without parity, ch3 arrives on the firing cycle itself.
  always_comb begin
    frame_nxt = '0;
    for (int k = 0; k < NCH; k++) begin
      frame_nxt[k*DW +: DW] = hold[k];
    end
`ifndef TDM_DEMUX_PARITY_EN
    frame_nxt[(NCH-1)*DW +: DW] = din;
`endif
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic parity_ok;
  assign parity_ok  = ~^{frame_nxt, din};
  assign frame_fire = wrap && parity_ok;
  assign hold_we    = accept && !cnt[SLOT_W-1];
`else
  assign frame_fire = wrap;
  assign hold_we    = accept;
`endif

  // NOTE: the holding registers are a small array but are explicitly reset, not left as RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) hold[k] <= '0;
    end else if (load_ch0) begin
      hold[0] <= din;
    end else if (hold_we) begin
      hold[cnt[NCH_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= frame_fire;
      sync_err    <= sync_bad;
      if (frame_fire) y <= frame_nxt;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= wrap && !parity_ok;
  end
`endif

  assign locked = (state == LOCKED);
  assign slot   = cnt[NCH_W-1:0];

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed steps followed by randomized traffic
// compared against a slot-position reference model.
module tb_tdm_demux4;

  localparam int DW  = 1;
  localparam int NCH = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int NSLOT = 5;
`else
  localparam int NSLOT = 4;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     din;
  logic              din_valid;
  logic              sync;
  logic [NCH*DW-1:0] y;
  logic              frame_valid;
  logic [1:0]        slot;
  logic              locked;
  logic              sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic              parity_err;
`endif

  always #5 clk = ~clk;

  tdm_demux4 #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .y           (y),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .sync_err    (sync_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: position within the frame plus the slots received so far.
  bit                m_locked = 1'b0;
  int                m_pos    = 0;
  logic [DW-1:0]     m_fr [NSLOT];
  logic [NCH*DW-1:0] m_y    = '0;
  bit                m_fv   = 1'b0;
  bit                m_se   = 1'b0;
  bit                m_pe   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic s, input logic [DW-1:0] d);
    logic [NCH*DW-1:0] f;
    logic              par;
    m_fv = 1'b0;
    m_se = 1'b0;
    m_pe = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_pos    = 0;
      m_y      = '0;
    end else if (v) begin
      if (s) begin
        m_se     = m_locked && (m_pos != 0);
        m_locked = 1'b1;
        m_fr[0]  = d;
        m_pos    = 1;
      end else if (m_locked) begin
        m_fr[m_pos] = d;
        if (m_pos == NSLOT - 1) begin
          f   = '0;
          par = 1'b0;
          for (int k = 0; k < NCH; k++) f[k*DW +: DW] = m_fr[k];
          for (int k = 0; k < NSLOT; k++) par = par ^ (^m_fr[k]);
          if (NSLOT == NCH || par == 1'b0) begin
            m_y  = f;
            m_fv = 1'b1;
          end else begin
            m_pe = 1'b1;
          end
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d, input logic r = 1'b0);
    rst       = r;
    din_valid = v;
    sync      = s;
    din       = d;
    @(posedge clk);
    model_edge(r, v, s, d);
    #1;
    check("y", 64'(y), 64'(m_y));
    check("frame_valid", 64'(frame_valid), 64'(m_fv));
    check("sync_err", 64'(sync_err), 64'(m_se));
    check("slot", 64'(slot), 64'(m_pos % 4));
    check("locked", 64'(locked), 64'(m_locked));
    check("fv_se_exclusive", 64'(frame_valid & sync_err), 64'd0);
`ifdef TDM_DEMUX_PARITY_EN
    check("parity_err", 64'(parity_err), 64'(m_pe));
`endif
  endtask

  // Sends one aligned frame; with parity enabled a correct even-parity slot follows.
  task automatic send_frame(input logic [NCH*DW-1:0] f);
    logic [DW-1:0] p;
    for (int k = 0; k < NCH; k++) step(1'b1, k == 0, f[k*DW +: DW]);
`ifdef TDM_DEMUX_PARITY_EN
    p    = '0;
    p[0] = ^f;
    step(1'b1, 1'b0, p);
`endif
    p = '0;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0;

    // Reset, including a sync asserted during reset, then idle data in HUNT.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_y", 64'(y), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_slot", 64'(slot), 64'd0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("hunt_locked", 64'(locked), 64'd0);
    check("hunt_fv", 64'(frame_valid), 64'd0);

    // Aligned frames.
    send_frame(4'b0001);
    check("aligned_y0", 64'(y), 64'h1);
    check("aligned_fv0", 64'(frame_valid), 64'd1);
    send_frame(4'b0010);
    check("aligned_y1", 64'(y), 64'h2);

    // Stall between slots 1 and 2.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check("stall_slot", 64'(slot), 64'd2);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, 1'b1);
`endif
    check("stall_y", 64'(y), 64'hd);
    check("stall_fv", 64'(frame_valid), 64'd1);

    // Misaligned sync after two slots.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("missync_err", 64'(sync_err), 64'd1);
    check("missync_slot", 64'(slot), 64'd1);
    check("missync_fv", 64'(frame_valid), 64'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, 1'b0);
`endif
    check("missync_y", 64'(y), 64'h5);

    // Reset in the middle of a frame.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("midrst_slot", 64'(slot), 64'd0);
    check("midrst_locked", 64'(locked), 64'd0);
    check("midrst_y", 64'(y), 64'd0);
    step(1'b1, 1'b0, 1'b1);
    send_frame(4'b0100);
    check("midrst_next_y", 64'(y), 64'h4);

`ifdef TDM_DEMUX_PARITY_EN
    // Parity slot: good parity then bad parity on the same frame.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("par_ok_y", 64'(y), 64'h3);
    check("par_ok_fv", 64'(frame_valid), 64'd1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("par_bad_err", 64'(parity_err), 64'd1);
    check("par_bad_y", 64'(y), 64'h3);
    check("par_bad_fv", 64'(frame_valid), 64'd0);
`endif

    // Randomized traffic: mostly aligned syncs, some stalls, stray syncs and resets.
    for (int i = 0; i < 800; i++) begin
      logic          r;
      logic          v;
      logic          s;
      logic [DW-1:0] d;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = (m_pos == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 24) == 0);
      d = DW'($urandom);
      step(v, s, d, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
